// File: rtl/seq_frame_pkg.sv
// -----------------------------------------------------------------------------
// seq_frame_pkg
// Shared definitions for the serial frame transmitter: FSM state encodings,
// the sync marker and the stuffing threshold.
// The PARITY code is reserved here in every build. The transmitter only uses
// it when SEQ_FRAME_TX_PARITY_EN is defined.
// -----------------------------------------------------------------------------
package seq_frame_pkg;

  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] ENC_IDLE   = 3'b000;
  localparam logic [STATE_W-1:0] ENC_SYNC   = 3'b001;
  localparam logic [STATE_W-1:0] ENC_DATA   = 3'b010;
  localparam logic [STATE_W-1:0] ENC_STUFF  = 3'b011;
  localparam logic [STATE_W-1:0] ENC_PARITY = 3'b100;
  localparam logic [STATE_W-1:0] ENC_GAP    = 3'b101;

  typedef enum logic [STATE_W-1:0] {
    IDLE   = ENC_IDLE,
    SYNC   = ENC_SYNC,
    DATA   = ENC_DATA,
    STUFF  = ENC_STUFF,
    PARITY = ENC_PARITY,
    GAP    = ENC_GAP
  } state_t;

  localparam int                SYNC_W       = 4;
  localparam logic [SYNC_W-1:0] SYNC_PATTERN = 4'b1110;
  localparam int                SYNC_CNT_W   = $clog2(SYNC_W);

  // A zero is forced after this many consecutive ones on the line.
  localparam int STUFF_THRESH = 2;
  localparam int RUN_W        = $clog2(STUFF_THRESH + 1);

  // Marker bit for sync position idx, with the MSB sent first.
  function automatic logic sync_bit(input logic [SYNC_CNT_W-1:0] idx);
    logic [SYNC_W-1:0] pat;
    pat = SYNC_PATTERN << idx;
    return pat[SYNC_W-1];
  endfunction

endpackage

// File: rtl/seq_frame_tx_if.sv
// -----------------------------------------------------------------------------
// seq_frame_tx_if
// Payload handshake and serial line bundle for seq_frame_tx.
//   in_data/in_valid : payload word from the producer
//   in_ready         : transmitter can accept a word
//   tx_bit/tx_en     : registered serial line and frame-bit qualifier
//   state            : FSM state for debug
// The master modport is the payload producer. The slave modport is the
// transmitter.
// -----------------------------------------------------------------------------
interface seq_frame_tx_if
  import seq_frame_pkg::*;
#(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0]  in_data;
  logic               in_valid;
  logic               in_ready;
  logic               tx_bit;
  logic               tx_en;
  logic [STATE_W-1:0] state;

  modport master (
    output in_data, in_valid,
    input  in_ready, tx_bit, tx_en, state
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, tx_bit, tx_en, state
  );
endinterface

// File: rtl/seq_frame_stuffer.sv
// -----------------------------------------------------------------------------
// seq_frame_stuffer
// Tracks the run of consecutive ones put on the line and asks for a stuffed
// zero when the bit being emitted completes a run of STUFF_THRESH ones.
//   clk, rst    : clock, synchronous active-high reset
//   clear       : zero the run counter (takes priority over bit_emitted)
//   bit_emitted : a stuffing-relevant bit goes out on this edge
//   bit_value   : value of that bit
//   stuff_req   : combinational; the next line bit must be a stuffed 0
// -----------------------------------------------------------------------------
module seq_frame_stuffer
  import seq_frame_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic bit_emitted,
  input  logic bit_value,
  output logic stuff_req
);

  logic [RUN_W-1:0] run_cnt;

  // NOTE: state registers take non-blocking assignments so every flop samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      run_cnt <= '0;
    end else if (clear) begin
      run_cnt <= '0;
    end else if (bit_emitted) begin
      run_cnt <= bit_value ? run_cnt + 1'b1 : '0;
    end
  end

  // Look ahead: the decision has to be made on the same edge that emits the
  // run-completing one, so the FSM can branch straight into STUFF.
  assign stuff_req = bit_emitted && bit_value &&
                     (run_cnt == RUN_W'(STUFF_THRESH - 1));

endmodule

// File: rtl/seq_frame_tx.sv
// -----------------------------------------------------------------------------
// seq_frame_tx
// Serial frame transmitter. A frame is the marker 1110 followed by the payload
// MSB first. A zero is stuffed after every pair of ones, so 111 appears only
// in the marker. One line bit is sent per clock. tx_bit and tx_en are
// registered, so they lag the FSM state by one cycle.
//   clk, rst : clock, synchronous active-high reset
//   bus      : seq_frame_tx_if.slave (in_data, in_valid, in_ready, tx_bit,
//              tx_en, state)
// Optional build macro SEQ_FRAME_TX_PARITY_EN adds an even-parity bit after the
// payload. The parity bit also takes part in stuffing.
// -----------------------------------------------------------------------------
module seq_frame_tx
  import seq_frame_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic          clk,
  input  logic          rst,
  seq_frame_tx_if.slave bus
);

  localparam int CNT_W = $clog2(DATA_W + 1);

`ifdef SEQ_FRAME_TX_PARITY_EN
  localparam state_t TAIL_ST = PARITY;
`else
  localparam state_t TAIL_ST = GAP;
`endif

  state_t                state_q, state_d;
  logic [DATA_W-1:0]     shreg;
  logic [CNT_W-1:0]      bit_cnt;     // payload bits still to send
  logic [SYNC_CNT_W-1:0] sync_cnt;
  logic                  tx_bit_q, tx_en_q;
  logic                  emit_bit, emit_en;
  logic                  accept;
  logic                  stf_emit, stf_value, stf_clear, stuff_req;
`ifdef SEQ_FRAME_TX_PARITY_EN
  logic                  par_acc;     // XOR of payload bits sent so far
  logic                  par_sent;
`endif

  assign bus.in_ready = (state_q == IDLE) && !rst;
  assign accept       = bus.in_valid && bus.in_ready;
  assign bus.tx_bit   = tx_bit_q;
  assign bus.tx_en    = tx_en_q;
  assign bus.state    = state_q;

  // Stuffer inputs come straight from the state register. That keeps them
  // out of the next-state block that consumes stuff_req.
`ifdef SEQ_FRAME_TX_PARITY_EN
  assign stf_emit  = (state_q == DATA) || (state_q == PARITY);
  assign stf_value = (state_q == PARITY) ? par_acc : shreg[DATA_W-1];
`else
  assign stf_emit  = (state_q == DATA);
  assign stf_value = shreg[DATA_W-1];
`endif
  assign stf_clear = (state_q == IDLE) || (state_q == SYNC) || (state_q == STUFF);

  seq_frame_stuffer u_stuffer (
    .clk         (clk),
    .rst         (rst),
    .clear       (stf_clear),
    .bit_emitted (stf_emit),
    .bit_value   (stf_value),
    .stuff_req   (stuff_req)
  );

  // NOTE: every output of this block gets a default first, so no path leaves
  // a variable unassigned and no latch can be inferred.
  always_comb begin
    state_d  = state_q;
    emit_bit = 1'b0;
    emit_en  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) state_d = SYNC;
      end
      SYNC: begin
        emit_en  = 1'b1;
        emit_bit = sync_bit(sync_cnt);
        if (sync_cnt == SYNC_CNT_W'(SYNC_W - 1)) state_d = DATA;
      end
      DATA: begin
        emit_en  = 1'b1;
        emit_bit = shreg[DATA_W-1];
        if (stuff_req)                    state_d = STUFF;
        else if (bit_cnt == CNT_W'(1))    state_d = TAIL_ST;
      end
      STUFF: begin
        emit_en = 1'b1;
        if (bit_cnt != '0)                state_d = DATA;
`ifdef SEQ_FRAME_TX_PARITY_EN
        else if (!par_sent)               state_d = PARITY;
`endif
        else                              state_d = GAP;
      end
`ifdef SEQ_FRAME_TX_PARITY_EN
      PARITY: begin
        emit_en  = 1'b1;
        emit_bit = par_acc;
        state_d  = stuff_req ? STUFF : GAP;
      end
`endif
      GAP: begin
        state_d = IDLE;
      end
      // Unused codes return to IDLE with the line quiet.
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      tx_bit_q <= 1'b0;
      tx_en_q  <= 1'b0;
      shreg    <= '0;
      bit_cnt  <= '0;
      sync_cnt <= '0;
`ifdef SEQ_FRAME_TX_PARITY_EN
      par_acc  <= 1'b0;
      par_sent <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      tx_bit_q <= emit_bit;
      tx_en_q  <= emit_en;
      if (accept) begin
        shreg    <= bus.in_data;
        bit_cnt  <= CNT_W'(DATA_W);
        sync_cnt <= '0;
`ifdef SEQ_FRAME_TX_PARITY_EN
        par_acc  <= 1'b0;
        par_sent <= 1'b0;
`endif
      end
      // sync_cnt wraps back to zero as the marker completes.
      if (state_q == SYNC) sync_cnt <= sync_cnt + 1'b1;
      if (state_q == DATA) begin
        shreg   <= shreg << 1;
        bit_cnt <= bit_cnt - 1'b1;
`ifdef SEQ_FRAME_TX_PARITY_EN
        par_acc <= par_acc ^ shreg[DATA_W-1];
`endif
      end
`ifdef SEQ_FRAME_TX_PARITY_EN
      if (state_q == PARITY) par_sent <= 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_seq_frame_tx.sv
// -----------------------------------------------------------------------------
// tb_seq_frame_tx
// Self-checking bench for seq_frame_tx (DATA_W = 8). It runs directed frames
// and random payloads. Random payloads are compared against a reference model
// that builds the expected line bits with queues. Define SEQ_FRAME_TX_PARITY_EN
// for both the bench and the RTL to cover the parity build.
// -----------------------------------------------------------------------------
module tb_seq_frame_tx;

  localparam logic [2:0] S_IDLE  = 3'b000;
  localparam logic [2:0] S_SYNC  = 3'b001;
  localparam logic [2:0] S_STUFF = 3'b011;
  localparam logic [2:0] S_GAP   = 3'b101;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seq_frame_tx_if #(.DATA_W(8)) bus ();

  seq_frame_tx #(.DATA_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Line monitor: length of the last tx_en-low stretch, and a sticky flag set
  // if tx_bit is ever high while tx_en is low.
  int   low_run      = 0;
  int   last_low_run = 0;
  logic low_bit_err  = 1'b0;

  always @(negedge clk) begin
    if (bus.tx_en === 1'b1) begin
      if (low_run != 0) last_low_run <= low_run;
      low_run <= 0;
    end else begin
      low_run <= low_run + 1;
      if (bus.tx_bit === 1'b1) low_bit_err <= 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Reference model: marker, then payload MSB first (plus parity when
  // enabled). A 0 follows every second consecutive 1.
  function automatic void model(input logic [7:0] d, output logic [63:0] vec,
                                output int len, output int stuffs);
    bit         src[$];
    bit         q[$];
    logic [3:0] sync;
    int         run;
    sync   = 4'b1110;
    run    = 0;
    stuffs = 0;
    for (int i = 3; i >= 0; i--) q.push_back(sync[i]);
    for (int i = 7; i >= 0; i--) src.push_back(d[i]);
`ifdef SEQ_FRAME_TX_PARITY_EN
    src.push_back(^d);
`endif
    foreach (src[i]) begin
      q.push_back(src[i]);
      run = src[i] ? run + 1 : 0;
      if (run == 2) begin
        q.push_back(1'b0);
        stuffs++;
        run = 0;
      end
    end
    vec = '0;
    foreach (q[i]) vec = {vec[62:0], q[i]};
    len = q.size();
  endfunction

  // Sends one payload and captures the frame. Timing and protocol checks are
  // made along the way.
  task automatic run_frame(input logic [7:0] d, input bit keep_valid,
                           output logic [63:0] vec, output int len, output int stuffs);
    int         waited;
    bit         done;
    logic [2:0] prev_state;
    waited = 0;
    done   = 1'b0;
    vec    = '0;
    len    = 0;
    stuffs = 0;
    while (bus.in_ready !== 1'b1 && waited < 100) begin
      tick();
      waited++;
    end
    if (bus.in_ready !== 1'b1) begin
      check("ready_wait", {63'd0, bus.in_ready}, 64'd1);
      return;
    end
    bus.in_data  = d;
    bus.in_valid = 1'b1;
    tick();
    if (!keep_valid) bus.in_valid = 1'b0;
    check("accept_state", {61'd0, bus.state}, {61'd0, S_SYNC});
    prev_state = bus.state;
    for (int c = 0; c < 64 && !done; c++) begin
      tick();
      if (c == 0) check("first_bit_en", {63'd0, bus.tx_en}, 64'd1);
      if (bus.tx_en === 1'b1) begin
        vec = {vec[62:0], bus.tx_bit};
        len++;
      end else begin
        done = 1'b1;
        check("gap_state", {61'd0, prev_state}, {61'd0, S_GAP});
        check("idle_state", {61'd0, bus.state}, {61'd0, S_IDLE});
        check("ready_after_gap", {63'd0, bus.in_ready}, 64'd1);
        check("line_low", {63'd0, bus.tx_bit}, 64'd0);
      end
      if (bus.state === S_STUFF) stuffs++;
      prev_state = bus.state;
    end
    check("frame_end_seen", {63'd0, done}, 64'd1);
  endtask

  task automatic verify_frame(input string tag, input logic [7:0] d, input bit keep,
                              input logic [63:0] ev, input int el, input int es);
    logic [63:0] v;
    int          l, s, m;
    run_frame(d, keep, v, l, s);
    check({tag, "_bits"}, v, ev);
    check({tag, "_len"}, 64'(l), 64'(el));
    check({tag, "_stuffs"}, 64'(s), 64'(es));
    m = 0;
    for (int i = 0; i + 2 < l; i++) if (v[i +: 3] == 3'b111) m++;
    check({tag, "_one_marker"}, 64'(m), 64'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] ev;
    logic [7:0]  d;
    int          el, es;

    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    repeat (3) tick();
    check("rst_tx_bit", {63'd0, bus.tx_bit}, 64'd0);
    check("rst_tx_en", {63'd0, bus.tx_en}, 64'd0);
    check("rst_state", {61'd0, bus.state}, {61'd0, S_IDLE});
    check("rst_in_ready", {63'd0, bus.in_ready}, 64'd0);
    rst = 1'b0;
    tick();
    check("ready_after_rst", {63'd0, bus.in_ready}, 64'd1);

`ifdef SEQ_FRAME_TX_PARITY_EN
    verify_frame("a5", 8'hA5, 1'b0, 64'b1110_10100101_0, 13, 0);
    verify_frame("ff", 8'hFF, 1'b0, 64'b1110_110110110110_0, 17, 4);
    verify_frame("01", 8'h01, 1'b0, 64'b1110_00000001_1_0, 14, 1);
    verify_frame("03", 8'h03, 1'b0, 64'b1110_00000011_0_0, 14, 1);
    ev = 64'b1110_0110011010_1;
    el = 15;
`else
    verify_frame("a5", 8'hA5, 1'b0, 64'b1110_10100101, 12, 0);
    verify_frame("ff", 8'hFF, 1'b0, 64'b1110_110110110110, 16, 4);
    verify_frame("03", 8'h03, 1'b0, 64'b1110_00000011_0, 13, 1);
    ev = 64'b1110_0110011010;
    el = 14;
`endif

    // Back-to-back with in_valid held high across the frame boundary.
    verify_frame("6e_first", 8'h6E, 1'b1, ev, el, 2);
    verify_frame("6e_second", 8'h6E, 1'b0, ev, el, 2);
    check("b2b_low_cycles", 64'(last_low_run), 64'd2);

    // Reset while the 3rd payload bit of 0xFF is on the line.
    bus.in_data  = 8'hFF;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    repeat (8) tick();
    check("mid_bit3_en", {63'd0, bus.tx_en}, 64'd1);
    check("mid_bit3_val", {63'd0, bus.tx_bit}, 64'd1);
    rst = 1'b1;
    tick();
    check("mid_rst_tx_en", {63'd0, bus.tx_en}, 64'd0);
    check("mid_rst_tx_bit", {63'd0, bus.tx_bit}, 64'd0);
    check("mid_rst_state", {61'd0, bus.state}, {61'd0, S_IDLE});
    rst = 1'b0;
    model(8'hA5, ev, el, es);
    verify_frame("a5_after_rst", 8'hA5, 1'b0, ev, el, es);

    // Random payloads against the reference model.
    for (int i = 0; i < 12; i++) begin
      d = 8'($urandom_range(0, 255));
      model(d, ev, el, es);
      verify_frame($sformatf("rand%0d_%02h", i, d), d, 1'b0, ev, el, es);
    end

    check("quiet_line", {63'd0, low_bit_err}, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/seq_frame_tx.md
# seq_frame_tx

Serial frame transmitter for the sync-detecting Moore receivers in the FSM library: accepts a parallel payload word over a valid/ready handshake and emits it one bit per clock. Each frame is the sync marker 1110, then the payload MSB-first with zero-bit stuffing so that no 111 run can occur outside the marker. The block drives the single-bit serial line consumed by the sequence-detector FSMs.

## Interface
- DATA_W, default 8: payload width in bits, minimum 2.
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_data  in  DATA_W  payload word; sampled on the accept edge.
- in_valid  in  1  payload present.
- in_ready  out  1  block can accept; combinational, equals (state==IDLE) && !rst.
- tx_bit  out  1  serial line, registered.
- tx_en  out  1  high while tx_bit carries a frame bit, registered.
- state  out  3  current FSM state, for debug and bench.

## Operation
- States (3-bit encoding):
  - IDLE=000
  - SYNC=001
  - DATA=010
  - STUFF=011
  - PARITY=100 (parity build only)
  - GAP=101
  - Codes 110 and 111 are illegal and return to IDLE on the next edge, driving tx_bit=0 and tx_en=0.
- IDLE: tx_bit=0, tx_en=0. in_valid && in_ready at an edge latches in_data into a shift register and moves to SYNC.
- SYNC: emits 1,1,1,0 over four cycles, then moves to DATA. The ones-run counter is cleared at DATA entry.
- DATA: emits the shift register MSB first, one bit per cycle.
  - A run counter counts consecutive emitted 1s and clears on any emitted 0.
  - When two consecutive 1s have been emitted, the next cycle is STUFF.
- STUFF: emits 0 with tx_en=1 and clears the run counter. It then resumes DATA, or goes to PARITY or GAP if all payload bits are already sent.
- Stuffing is mandatory after the final payload bits too. A payload ending in 11 is always followed by a stuffed 0.
- GAP: one cycle with tx_bit=0, tx_en=0, in_ready=0, then IDLE.
- Frame length on tx_en = 4 + DATA_W + number of stuffed zeros (+1 parity bit, +stuffs after it, when enabled).
- The payload alone never contains 111, and tx_bit is 0 while tx_en is low. The receiver therefore detects 1110 only at the marker, and the sync detector fires exactly once per frame.
- in_valid while busy: ignored; in_data is not sampled.
- Reset values: state=IDLE, tx_bit=0, tx_en=0, shift register=0, run counter=0. in_ready=0 while rst is high and 1 on the first cycle after.
- Reset mid-frame: the next edge returns to IDLE with tx_bit=0 and tx_en=0. The partial frame is abandoned; there is no GAP and no completion.

## Timing
- The accept edge is k. The first sync bit appears on tx_bit/tx_en after edge k+1. The last frame bit is followed by one GAP cycle.
- in_ready rises in the cycle after GAP. Minimum spacing between accept edges is frame length + 2 cycles.
- Back-to-back traffic with in_valid held high: frames are separated by exactly one GAP cycle plus the IDLE accept cycle, i.e. two tx_en-low cycles.
- Throughput is one line bit per clock, with no stalls inside a frame.

## Configuration
- SEQ_FRAME_TX_PARITY_EN defined:
  - After the last payload bit, and after any pending stuff bit, the PARITY state emits the even parity of the DATA_W payload bits.
  - Stuffed bits are excluded from the parity computation.
  - The parity bit counts toward the ones run, so 11 ending at the parity bit is followed by a stuffed 0.
- Undefined: the PARITY state is absent, DATA/STUFF go directly to GAP, and code 100 is treated as illegal.

## Structure
- Package seq_frame_pkg holds:
  - the state encodings (localparams)
  - SYNC_PATTERN=4'b1110 and SYNC_W=4
  - the stuff threshold value 2
- Sub-module seq_frame_stuffer holds the run counter and stuff-request logic:
  - inputs: clk, rst, clear, bit_emitted, bit_value
  - output: stuff_req
- The top level holds the FSM, shift register, bit counter and parity accumulator.

## Test plan
- Reset: hold rst 3 cycles → tx_bit=0, tx_en=0, state=000, in_ready=0. One cycle after release, in_ready=1.
- Payload 8'hA5 → tx_bit sequence 1110 10100101 (12 cycles tx_en=1, no stuffing), then GAP, then in_ready=1.
- Payload 8'hFF → 1110 110110110110 (16 tx_en cycles, 4 stuffs); state visits 011 four times.
- Payload 8'h6E, then 8'h6E again, with in_valid held high → each frame is 1110 0110011010, separated by exactly 2 tx_en-low cycles with tx_bit=0.
- Assert rst during the 3rd payload bit of an 8'hFF frame → next cycle tx_en=0, tx_bit=0, state=000; a following 8'hA5 transmits intact.
- With SEQ_FRAME_TX_PARITY_EN:
  - 8'h01 → 1110 00000001 1 0 (parity 1, then a stuffed 0).
  - 8'hFF → 1110 110110110110 0.
